// File: rtl/tl_sram_responder.sv
// tl_sram_responder: TileLink-UH manager terminating a client A/D port in front of a
// single-port synchronous SRAM of 64-bit words. It serves Get, PutFull and PutPartial,
// including multi-beat bursts up to 2**MAX_SIZE bytes, with one request in flight.
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   auto_in_a_*                  A channel: request beats from the client
//   auto_in_d_*                  D channel: AccessAck / AccessAckData responses
//
// Optional feature: define TL_RESP_DENY_OOR_EN to refuse requests whose address lies at
// or above DEPTH_WORDS*8. When it is not defined, upper address bits are ignored and the
// word index wraps modulo DEPTH_WORDS.
module tl_sram_responder #(
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned SRC_W       = 7,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned MAX_SIZE    = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              auto_in_a_valid,
    output logic              auto_in_a_ready,
    input  logic [2:0]        auto_in_a_bits_opcode,
    input  logic [2:0]        auto_in_a_bits_param,
    input  logic [2:0]        auto_in_a_bits_size,
    input  logic [SRC_W-1:0]  auto_in_a_bits_source,
    input  logic [ADDR_W-1:0] auto_in_a_bits_address,
    input  logic [7:0]        auto_in_a_bits_mask,
    input  logic [63:0]       auto_in_a_bits_data,
    input  logic              auto_in_a_bits_corrupt,
    input  logic              auto_in_d_ready,
    output logic              auto_in_d_valid,
    output logic [2:0]        auto_in_d_bits_opcode,
    output logic [1:0]        auto_in_d_bits_param,
    output logic [2:0]        auto_in_d_bits_size,
    output logic [SRC_W-1:0]  auto_in_d_bits_source,
    output logic              auto_in_d_bits_sink,
    output logic              auto_in_d_bits_denied,
    output logic [63:0]       auto_in_d_bits_data,
    output logic              auto_in_d_bits_corrupt
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned BEAT_W = (MAX_SIZE > 3) ? (MAX_SIZE - 3) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GET, S_PUT, S_ACK} state_t;

    state_t             r_state, w_state_nxt;
    logic [BEAT_W-1:0]  r_beat, w_beat_nxt, r_last;
    logic [IDX_W-1:0]   r_base;
    logic [2:0]         r_size;
    logic [SRC_W-1:0]   r_source;
    logic               r_denied;
    logic               r_a_ready, w_a_ready_nxt;
    logic               r_d_valid, w_d_valid_nxt;
    logic [2:0]         r_d_opcode, w_d_opcode_nxt;
    logic               r_d_denied, w_d_denied_nxt;
    logic               r_d_corrupt, w_d_corrupt_nxt;
    logic [63:0]        r_d_data;
    logic [63:0]        r_mem [DEPTH_WORDS];

    logic               w_latch, w_d_load, w_rd_en, w_wr_en;
    logic [IDX_W-1:0]   w_rd_idx, w_wr_idx, w_cur_idx;

    // Request decode on the A channel
    logic               w_a_fire, w_d_fire, w_a_get, w_a_put, w_a_oor, w_a_deny;
    logic [BEAT_W-1:0]  w_a_beats_m1;
    logic [IDX_W-1:0]   w_a_base;

    assign w_a_fire  = auto_in_a_valid & r_a_ready;
    assign w_d_fire  = r_d_valid & auto_in_d_ready;
    assign w_a_get   = (auto_in_a_bits_opcode == 3'd4);
    assign w_a_put   = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    assign w_a_base  = auto_in_a_bits_address[IDX_W+2:3];
    assign w_cur_idx = r_base + IDX_W'(r_beat);
    assign w_a_beats_m1 = (auto_in_a_bits_size <= 3'd3) ? '0
                        : BEAT_W'((32'd1 << (auto_in_a_bits_size - 3'd3)) - 32'd1);
`ifdef TL_RESP_DENY_OOR_EN
    assign w_a_oor   = |(auto_in_a_bits_address >> (IDX_W + 3));
`else
    assign w_a_oor   = 1'b0;
`endif
    assign w_a_deny  = !(w_a_get || w_a_put) || w_a_oor;

    logic w_unused;
    assign w_unused = ^{auto_in_a_bits_param, auto_in_a_bits_address};

    // Next-state and response control
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        w_d_valid_nxt   = r_d_valid;
        w_d_opcode_nxt  = r_d_opcode;
        w_d_denied_nxt  = r_d_denied;
        w_d_corrupt_nxt = r_d_corrupt;
        w_latch         = 1'b0;
        w_d_load        = 1'b0;
        w_rd_en         = 1'b0;
        w_rd_idx        = w_cur_idx;
        w_wr_en         = 1'b0;
        w_wr_idx        = w_cur_idx;
        unique case (r_state)
            S_IDLE: begin
                if (w_a_fire) begin
                    w_latch    = 1'b1;
                    w_beat_nxt = '0;
                    if (w_a_get) begin
                        w_state_nxt     = S_GET;
                        w_d_valid_nxt   = 1'b1;
                        w_d_opcode_nxt  = 3'd1;
                        w_d_denied_nxt  = w_a_deny;
                        w_d_corrupt_nxt = w_a_deny;
                        w_d_load        = 1'b1;
                        w_rd_en         = !w_a_deny;
                        w_rd_idx        = w_a_base;
                    end else begin
                        // Puts write their first beat here; unsupported opcodes never write
                        w_wr_en  = w_a_put && !w_a_deny && !auto_in_a_bits_corrupt;
                        w_wr_idx = w_a_base;
                        if (w_a_put && (w_a_beats_m1 != '0)) begin
                            w_state_nxt = S_PUT;
                            w_beat_nxt  = BEAT_W'(1);
                        end else begin
                            w_state_nxt     = S_ACK;
                            w_d_valid_nxt   = 1'b1;
                            w_d_opcode_nxt  = 3'd0;
                            w_d_denied_nxt  = w_a_deny;
                            w_d_corrupt_nxt = 1'b0;
                            w_d_load        = 1'b1;
                        end
                    end
                end
            end
            S_GET: begin
                // Advance only on a D fire so the presented beat holds while stalled
                if (w_d_fire) begin
                    if (r_beat == r_last) begin
                        w_state_nxt   = S_IDLE;
                        w_beat_nxt    = '0;
                        w_d_valid_nxt = 1'b0;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                        w_d_load   = 1'b1;
                        w_rd_en    = !r_denied;
                        w_rd_idx   = r_base + IDX_W'(w_beat_nxt);
                    end
                end
            end
            S_PUT: begin
                if (w_a_fire) begin
                    w_wr_en = !r_denied && !auto_in_a_bits_corrupt;
                    if (r_beat == r_last) begin
                        w_state_nxt     = S_ACK;
                        w_beat_nxt      = '0;
                        w_d_valid_nxt   = 1'b1;
                        w_d_opcode_nxt  = 3'd0;
                        w_d_denied_nxt  = r_denied;
                        w_d_corrupt_nxt = 1'b0;
                        w_d_load        = 1'b1;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end
            end
            S_ACK: begin
                if (w_d_fire) begin
                    w_state_nxt   = S_IDLE;
                    w_d_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_a_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_PUT);
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Request context, beat counter and registered D channel
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_beat      <= '0;
            r_last      <= '0;
            r_base      <= '0;
            r_size      <= '0;
            r_source    <= '0;
            r_denied    <= 1'b0;
            r_a_ready   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_opcode  <= '0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= '0;
        end else begin
            if (w_latch) begin
                r_last   <= w_a_beats_m1;
                r_base   <= w_a_base;
                r_size   <= auto_in_a_bits_size;
                r_source <= auto_in_a_bits_source;
                r_denied <= w_a_deny;
            end
            r_beat      <= w_beat_nxt;
            r_a_ready   <= w_a_ready_nxt;
            r_d_valid   <= w_d_valid_nxt;
            r_d_opcode  <= w_d_opcode_nxt;
            r_d_denied  <= w_d_denied_nxt;
            r_d_corrupt <= w_d_corrupt_nxt;
            if (w_d_load) r_d_data <= w_rd_en ? r_mem[w_rd_idx] : 64'd0;
        end
    end

    // SRAM byte-lane write port; contents survive reset
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) r_mem[w_wr_idx][b*8 +: 8] <= auto_in_a_bits_data[b*8 +: 8];
            end
        end
    end

    a_size_in_contract: assert property (@(posedge clock) disable iff (!reset)
        w_a_fire |-> (auto_in_a_bits_size <= 3'(MAX_SIZE)));

    assign auto_in_a_ready        = r_a_ready;
    assign auto_in_d_valid        = r_d_valid;
    assign auto_in_d_bits_opcode  = r_d_opcode;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = r_size;
    assign auto_in_d_bits_source  = r_source;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = r_d_denied;
    assign auto_in_d_bits_data    = r_d_data;
    assign auto_in_d_bits_corrupt = r_d_corrupt;

endmodule

// File: tb/tb_tl_sram_responder.sv
// tb_tl_sram_responder: directed bench for tl_sram_responder. Single-beat requests come
// from a vector table; bursts, D back-pressure and mid-burst reset are hand sequences.
module tb_tl_sram_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0, a_ready, a_corrupt = 1'b0;
    logic [2:0]  a_opcode = '0, a_param = '0, a_size = '0;
    logic [6:0]  a_source = '0;
    logic [20:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        d_ready = 1'b1, d_valid, d_sink, d_denied, d_corrupt;
    logic [2:0]  d_opcode, d_size;
    logic [1:0]  d_param;
    logic [6:0]  d_source;
    logic [63:0] d_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_sram_responder dut (
        .clock(clock), .reset(reset),
        .auto_in_a_valid(a_valid), .auto_in_a_ready(a_ready),
        .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
        .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
        .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
        .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
        .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
        .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_param(d_param),
        .auto_in_d_bits_size(d_size), .auto_in_d_bits_source(d_source),
        .auto_in_d_bits_sink(d_sink), .auto_in_d_bits_denied(d_denied),
        .auto_in_d_bits_data(d_data), .auto_in_d_bits_corrupt(d_corrupt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [20:0] addr;
        logic [6:0]  src;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
        logic [2:0]  e_op;
        logic        e_denied;
        logic [63:0] e_data;
        logic        e_corrupt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one A beat and hold it until accepted; returns just after the accepting edge
    task automatic a_beat(input logic [2:0] op, input logic [2:0] size, input logic [20:0] addr,
                          input logic [6:0] src, input logic [7:0] mask, input logic [63:0] data,
                          input logic corrupt, input string nm);
        int n = 0;
        @(negedge clock);
        a_valid = 1'b1; a_opcode = op; a_size = size; a_address = addr;
        a_source = src; a_mask = mask; a_data = data; a_corrupt = corrupt;
        while (!a_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!a_ready) begin
            checks++; errors++;
            $display("FAIL %s a_ready timeout: got 0 expected 1", nm);
        end else begin
            @(posedge clock);
        end
        #1 a_valid = 1'b0;
    endtask

    // Wait for a D beat (d_ready high) and compare its fields; the next edge consumes it
    task automatic d_beat(input logic [2:0] e_op, input logic e_den, input logic [63:0] e_data,
                          input logic e_cor, input logic [2:0] e_size, input logic [6:0] e_src,
                          input string nm, output int waited);
        d_ready = 1'b1;
        waited  = 0;
        @(negedge clock);
        while (!d_valid && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!d_valid) begin
            checks++; errors++;
            $display("FAIL %s d_valid timeout: got 0 expected 1", nm);
        end else begin
            chk({nm, " opcode"}, 64'(d_opcode), 64'(e_op));
            chk({nm, " denied"}, 64'(d_denied), 64'(e_den));
            chk({nm, " corrupt"}, 64'(d_corrupt), 64'(e_cor));
            chk({nm, " size"}, 64'(d_size), 64'(e_size));
            chk({nm, " source"}, 64'(d_source), 64'(e_src));
            chk({nm, " param/sink"}, 64'({d_param, d_sink}), 64'd0);
            if (e_op == 3'd1) chk({nm, " data"}, d_data, e_data);
        end
    endtask

    task automatic do_vec(input vec_t v, input string nm);
        int w;
        a_beat(v.op, v.size, v.addr, v.src, v.mask, v.data, v.corrupt, nm);
        chk({nm, " latency"}, 64'(d_valid), 64'd1);
        d_beat(v.e_op, v.e_denied, v.e_data, v.e_corrupt, v.size, v.src, nm, w);
    endtask

    initial begin
        int w;
        int beat;
        int cyc;
        vec_t v;

        //            op    sz    addr       src    mask   data                    cor   eop  den   edata                  ecor
        vecs[0]  = '{3'd0, 3'd3, 21'h00040, 7'd5,  8'hFF, 64'h1122334455667788, 1'b0, 3'd0, 1'b0, 64'h0,                 1'b0};
        vecs[1]  = '{3'd4, 3'd3, 21'h00040, 7'd9,  8'hFF, 64'h0,                 1'b0, 3'd1, 1'b0, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{3'd0, 3'd3, 21'h00048, 7'd1,  8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0, 1'b0, 64'h0,                 1'b0};
        vecs[3]  = '{3'd1, 3'd3, 21'h00048, 7'd2,  8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 3'd0, 1'b0, 64'h0,                 1'b0};
        vecs[4]  = '{3'd4, 3'd3, 21'h00048, 7'd3,  8'hFF, 64'h0,                 1'b0, 3'd1, 1'b0, 64'hFFFFFFFFAAAAAAAA, 1'b0};
        vecs[5]  = '{3'd2, 3'd3, 21'h00048, 7'd4,  8'hFF, 64'h0,                 1'b0, 3'd0, 1'b1, 64'h0,                 1'b0};
        vecs[6]  = '{3'd4, 3'd3, 21'h00048, 7'd6,  8'hFF, 64'h0,                 1'b0, 3'd1, 1'b0, 64'hFFFFFFFFAAAAAAAA, 1'b0};
        vecs[7]  = '{3'd0, 3'd3, 21'h00040, 7'd7,  8'hFF, 64'h0,                 1'b1, 3'd0, 1'b0, 64'h0,                 1'b0};
        vecs[8]  = '{3'd4, 3'd2, 21'h00044, 7'd8,  8'hFF, 64'h0,                 1'b0, 3'd1, 1'b0, 64'h1122334455667788, 1'b0};
        vecs[9]  = '{3'd0, 3'd3, 21'h00000, 7'd10, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 3'd0, 1'b0, 64'h0,                 1'b0};
`ifdef TL_RESP_DENY_OOR_EN
        vecs[10] = '{3'd4, 3'd3, 21'h10000, 7'd11, 8'hFF, 64'h0,                 1'b0, 3'd1, 1'b1, 64'h0,                 1'b1};
`else
        vecs[10] = '{3'd4, 3'd3, 21'h10000, 7'd11, 8'hFF, 64'h0,                 1'b0, 3'd1, 1'b0, 64'h0123456789ABCDEF, 1'b0};
`endif
        vecs[11] = '{3'd7, 3'd3, 21'h00000, 7'd12, 8'hFF, 64'h5555,              1'b0, 3'd0, 1'b1, 64'h0,                 1'b0};
        vecs[12] = '{3'd1, 3'd3, 21'h00000, 7'd13, 8'h80, 64'hEE00000000000000, 1'b0, 3'd0, 1'b0, 64'h0,                 1'b0};

        // Reset state
        #12;
        chk("reset a_ready", 64'(a_ready), 64'd0);
        chk("reset d_valid", 64'(d_valid), 64'd0);
        chk("reset d_fields", 64'({d_opcode, d_denied, d_corrupt, d_size, d_source}), 64'd0);
        chk("reset d_data", d_data, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) do_vec(vecs[i], $sformatf("vec%0d", i));
        v = '{3'd4, 3'd3, 21'h0, 7'd14, 8'hFF, 64'h0, 1'b0, 3'd1, 1'b0, 64'hEE23456789ABCDEF, 1'b0};
        do_vec(v, "partial_hi");

        // 8-beat PutFull: only one AccessAck, after the last beat
        for (int k = 0; k < 8; k++) begin
            a_beat(3'd0, 3'd6, 21'h100, 7'd20, 8'hFF, 64'(k), 1'b0, "burst_put");
            chk($sformatf("burst_put beat%0d d_valid", k), 64'(d_valid), (k == 7) ? 64'd1 : 64'd0);
        end
        d_beat(3'd0, 1'b0, 64'h0, 1'b0, 3'd6, 7'd20, "burst_put ack", w);

        // 8-beat Get at full rate
        a_beat(3'd4, 3'd6, 21'h100, 7'd21, 8'hFF, 64'h0, 1'b0, "burst_get");
        chk("burst_get latency", 64'(d_valid), 64'd1);
        for (int k = 0; k < 8; k++) begin
            d_beat(3'd1, 1'b0, 64'(k), 1'b0, 3'd6, 7'd21, $sformatf("burst_get beat%0d", k), w);
            chk($sformatf("burst_get b2b%0d", k), 64'(w), 64'd0);
        end
        @(negedge clock);
        chk("burst_get end d_valid", 64'(d_valid), 64'd0);

        // 8-beat Get under d_ready pattern 1,0,0: data must hold while stalled
        a_beat(3'd4, 3'd6, 21'h100, 7'd22, 8'hFF, 64'h0, 1'b0, "stall_get");
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 100) begin
            @(negedge clock);
            d_ready = (cyc % 3 == 0);
            cyc++;
            if (d_valid) begin
                chk($sformatf("stall_get beat%0d data", beat), d_data, 64'(beat));
                if (d_ready) beat++;
            end
        end
        chk("stall_get beats", 64'(beat), 64'd8);
        d_ready = 1'b1;
        @(negedge clock);
        chk("stall_get end d_valid", 64'(d_valid), 64'd0);

        // Reset during beat 3 of a burst Get, then a normal Get
        a_beat(3'd4, 3'd6, 21'h100, 7'd23, 8'hFF, 64'h0, 1'b0, "rst_get");
        for (int k = 0; k < 3; k++)
            d_beat(3'd1, 1'b0, 64'(k), 1'b0, 3'd6, 7'd23, $sformatf("rst_get beat%0d", k), w);
        @(negedge clock);
        chk("rst_get beat3 data", d_data, 64'd3);
        reset = 1'b0;
        #1;
        chk("rst_get d_valid", 64'(d_valid), 64'd0);
        chk("rst_get a_ready", 64'(a_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        v = '{3'd4, 3'd3, 21'h40, 7'd24, 8'hFF, 64'h0, 1'b0, 3'd1, 1'b0, 64'h1122334455667788, 1'b0};
        do_vec(v, "post_rst");
        v = '{3'd4, 3'd3, 21'h118, 7'd25, 8'hFF, 64'h0, 1'b0, 3'd1, 1'b0, 64'd3, 1'b0};
        do_vec(v, "post_rst burst word3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

endmodule
